// File: rtl/fifo_v3_prog.sv
// Synchronous FIFO with arbitrary depth, fill level, programmable almost-full/empty thresholds.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_V3_ERR_EN.
module fifo_v3_prog #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             testmode_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] usage_o,
    input  logic [CNT_W-1:0] alm_full_th_i,
    input  logic [CNT_W-1:0] alm_empty_th_i,
    output logic             alm_full_o,
    output logic             alm_empty_o,
    input  dtype             data_i,
    input  logic             push_i,
    output dtype             data_o,
`ifdef FIFO_V3_ERR_EN
    output logic             overflow_o,
    output logic             underflow_o,
    input  logic             err_clr_i,
`endif
    input  logic             pop_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    dtype             mem_q [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] usage_q, usage_d;

    logic is_empty;
    logic ft_active;
    logic push_ok;
    logic pop_ok;
    logic bypass;
    logic do_write;
    logic do_read;

    logic unused_testmode;
    assign unused_testmode = testmode_i;

    assign is_empty  = (usage_q == '0);
    // Fall-through presents the incoming beat while storage is empty.
    assign ft_active = FALL_THROUGH && is_empty && push_i;

    assign full_o      = (usage_q == CNT_W'(DEPTH));
    assign empty_o     = is_empty && !ft_active;
    assign usage_o     = usage_q;
    assign alm_full_o  = (usage_q >= alm_full_th_i);
    assign alm_empty_o = (usage_q <= alm_empty_th_i);

    assign push_ok  = push_i && (!full_o || pop_i);
    assign pop_ok   = pop_i && !empty_o;
    assign bypass   = ft_active && pop_i;
    assign do_write = push_ok && !bypass;
    assign do_read  = pop_ok && !bypass;

    always_comb begin
        data_o = mem_q[rptr_q];
        if (ft_active) begin
            data_o = data_i;
        end
    end

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        usage_d = usage_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            usage_d = '0;
        end else begin
            if (do_write) begin
                wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
            end
            if (do_read) begin
                rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
            end
            if (do_write && !do_read) begin
                usage_d = usage_q + CNT_W'(1);
            end else if (do_read && !do_write) begin
                usage_d = usage_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            usage_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            usage_q <= usage_d;
        end
    end

    // Flush leaves storage untouched; only pointers and the count are cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_write && !flush_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

`ifdef FIFO_V3_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (err_clr_i) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            // A new event in the same cycle as a clear keeps the flag set.
            if (push_i && full_o && !pop_i) begin
                overflow_d = 1'b1;
            end
            if (pop_i && empty_o) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_v3_prog.sv
// Bench for fifo_v3_prog: table-driven DEPTH=5 FIFO with a data scoreboard, plus a
// fall-through instance and hand sequences for flush, thresholds and async reset.
module tb_fifo_v3_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       testmode;
    logic       err_clr;

    // DUT A: DEPTH=5, registered output
    logic       a_flush, a_push, a_pop;
    logic [7:0] a_din, a_dout;
    logic [2:0] a_usage, a_afth, a_aeth;
    logic       a_full, a_empty, a_afull, a_aempty;
`ifdef FIFO_V3_ERR_EN
    logic       a_ovf, a_udf, b_ovf, b_udf;
`endif

    // DUT B: DEPTH=4, fall-through
    logic       b_flush, b_push, b_pop;
    logic [7:0] b_din, b_dout;
    logic [2:0] b_usage, b_afth, b_aeth;
    logic       b_full, b_empty, b_afull, b_aempty;

    fifo_v3_prog #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(5)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .testmode_i(testmode),
        .full_o(a_full), .empty_o(a_empty), .usage_o(a_usage),
        .alm_full_th_i(a_afth), .alm_empty_th_i(a_aeth),
        .alm_full_o(a_afull), .alm_empty_o(a_aempty),
        .data_i(a_din), .push_i(a_push), .data_o(a_dout),
`ifdef FIFO_V3_ERR_EN
        .overflow_o(a_ovf), .underflow_o(a_udf), .err_clr_i(err_clr),
`endif
        .pop_i(a_pop)
    );

    fifo_v3_prog #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .testmode_i(testmode),
        .full_o(b_full), .empty_o(b_empty), .usage_o(b_usage),
        .alm_full_th_i(b_afth), .alm_empty_th_i(b_aeth),
        .alm_full_o(b_afull), .alm_empty_o(b_aempty),
        .data_i(b_din), .push_i(b_push), .data_o(b_dout),
`ifdef FIFO_V3_ERR_EN
        .overflow_o(b_ovf), .underflow_o(b_udf), .err_clr_i(err_clr),
`endif
        .pop_i(b_pop)
    );

    typedef struct {
        logic        push;
        logic        pop;
        logic [7:0]  data;
        int unsigned usage;
        logic        full;
        logic        empty;
        logic        afull;
        logic        aempty;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         errors = 0;
    int         checks = 0;

    function automatic vec_t mk(logic push, logic pop, logic [7:0] data, int unsigned usage,
                                logic full, logic empty, logic afull, logic aempty);
        vec_t v;
        v.push = push; v.pop = pop; v.data = data; v.usage = usage;
        v.full = full; v.empty = empty; v.afull = afull; v.aempty = aempty;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on DUT A; the scoreboard tracks accepted beats independently of the DUT.
    task automatic a_cycle(input logic flush, input logic push, input logic pop,
                           input logic [7:0] data);
        bit do_push, do_pop;
        a_flush = flush; a_push = push; a_pop = pop; a_din = data;
        #1;
        do_pop  = pop && (sb.size() > 0);
        do_push = push && (sb.size() < 5 || pop);
        if (do_pop && !flush) check("scoreboard data_o", 32'(a_dout), 32'(sb[0]));
        tick();
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(data);
        end
        a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; testmode = 1'b0; err_clr = 1'b0;
        a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_din = '0;
        a_afth = 3'd3; a_aeth = 3'd1;
        b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_din = '0;
        b_afth = 3'd4; b_aeth = 3'd0;

        // Phase 1: fill 0x11..0x15, drain five
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 8'h11 + 8'(i), i + 1, i == 4, 0, i >= 2, i == 0));
        vecs.push_back(mk(0, 1, 8'h00, 4, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 3, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0, 1));
        // Phase 2: fill, dropped push, push+pop across pointer wrap, drain, pop on empty
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 8'h21 + 8'(i), i + 1, i == 4, 0, i >= 2, i == 0));
        vecs.push_back(mk(1, 0, 8'hAA, 5, 1, 0, 1, 0));
        for (int i = 0; i < 7; i++)
            vecs.push_back(mk(1, 1, 8'hA0 + 8'(i), 5, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 4, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 3, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h00, 2, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 1, 0, 1));

        // Reset state
        #2;
        check("reset usage", 32'(a_usage), 0);
        check("reset full", 32'(a_full), 0);
        check("reset empty", 32'(a_empty), 1);
        check("reset alm_full th=3", 32'(a_afull), 0);
        check("reset alm_empty", 32'(a_aempty), 1);
        check("reset b empty", 32'(b_empty), 1);
        a_afth = 3'd0;
        #1;
        check("reset alm_full th=0", 32'(a_afull), 1);
        a_afth = 3'd3;
        #9;
        rst = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            a_cycle(1'b0, vecs[i].push, vecs[i].pop, vecs[i].data);
            check($sformatf("row%0d usage", i), 32'(a_usage), vecs[i].usage);
            check($sformatf("row%0d full", i), 32'(a_full), 32'(vecs[i].full));
            check($sformatf("row%0d empty", i), 32'(a_empty), 32'(vecs[i].empty));
            check($sformatf("row%0d alm_full", i), 32'(a_afull), 32'(vecs[i].afull));
            check($sformatf("row%0d alm_empty", i), 32'(a_aempty), 32'(vecs[i].aempty));
        end
        check("scoreboard drained", 32'(sb.size()), 0);
`ifdef FIFO_V3_ERR_EN
        check("underflow sticky", 32'(a_udf), 1);
        check("overflow sticky", 32'(a_ovf), 1);
`endif

        // Flush at usage 4 while pushing; the pushed beat must be discarded
        for (int i = 0; i < 4; i++) a_cycle(1'b0, 1'b1, 1'b0, 8'h31 + 8'(i));
        a_cycle(1'b1, 1'b1, 1'b0, 8'h77);
        check("flush usage", 32'(a_usage), 0);
        check("flush empty", 32'(a_empty), 1);
        a_cycle(1'b0, 1'b1, 1'b0, 8'h88);
        check("post-flush usage", 32'(a_usage), 1);
        a_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check("post-flush empty", 32'(a_empty), 1);

        // Threshold change at usage 3 takes effect the same cycle
        for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b1, 1'b0, 8'h41 + 8'(i));
        check("th3 alm_full", 32'(a_afull), 1);
        a_afth = 3'd4;
        #1;
        check("th4 alm_full", 32'(a_afull), 0);
        a_afth = 3'd3;
        #1;
        check("th3 again alm_full", 32'(a_afull), 1);

        // Fill, drop a push, drain to 3, then async reset between edges
        a_cycle(1'b0, 1'b1, 1'b0, 8'h44);
        a_cycle(1'b0, 1'b1, 1'b0, 8'h45);
        a_cycle(1'b0, 1'b1, 1'b0, 8'h46);
        a_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        a_cycle(1'b0, 1'b0, 1'b1, 8'h00);
        check("pre-reset usage", 32'(a_usage), 3);
`ifdef FIFO_V3_ERR_EN
        check("pre-reset overflow", 32'(a_ovf), 1);
`endif
        #2;
        rst = 1'b1;
        #1;
        check("async reset usage", 32'(a_usage), 0);
        check("async reset empty", 32'(a_empty), 1);
`ifdef FIFO_V3_ERR_EN
        check("async reset overflow", 32'(a_ovf), 0);
`endif
        #1;
        rst = 1'b0;
        sb.delete();
        tick();

        // Fall-through: push+pop on empty bypasses storage
        b_push = 1'b1; b_pop = 1'b1; b_din = 8'h42;
        #1;
        check("ft bypass data_o", 32'(b_dout), 32'h42);
        check("ft bypass empty", 32'(b_empty), 0);
        tick();
        b_push = 1'b0; b_pop = 1'b0;
        #1;
        check("ft bypass usage", 32'(b_usage), 0);
        check("ft bypass empty after", 32'(b_empty), 1);
        // Fall-through push without pop is stored
        b_push = 1'b1; b_din = 8'h43;
        #1;
        check("ft push data_o", 32'(b_dout), 32'h43);
        check("ft push empty", 32'(b_empty), 0);
        tick();
        b_push = 1'b0;
        #1;
        check("ft stored usage", 32'(b_usage), 1);
        check("ft stored data_o", 32'(b_dout), 32'h43);
        b_pop = 1'b1;
        tick();
        b_pop = 1'b0;
        #1;
        check("ft drained usage", 32'(b_usage), 0);
        check("ft drained empty", 32'(b_empty), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
